// File: rtl/imm_decode_pipe.sv
// RV32I immediate generator for the decode stage. A decoded word goes to the output register.
// If that register is stalled, the word goes to a single skid register. in_ready comes only from skid state.
module imm_decode_pipe #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic             out_illegal,
   output logic [TAG_W-1:0] out_tag,
   output logic [CNT_W-1:0] illegal_cnt,
   input  logic             cnt_clr
);

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5
   } fmt_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   fmt_t             dec_fmt;
   logic [31:0]      imm32;
   logic [XLEN-1:0]  dec_imm;
   logic             dec_illegal;

   logic             skid_valid;
   logic [XLEN-1:0]  skid_imm;
   logic [2:0]       skid_fmt;
   logic             skid_illegal;
   logic [TAG_W-1:0] skid_tag;

   logic             accept;
   logic             drain;

   // Every format already carries instr[31] in bit 31, so widening to XLEN is a plain sign fill.
   always_comb begin
      dec_fmt     = FMT_NONE;
      imm32       = 32'd0;
      dec_illegal = 1'b0;
      case (in_instr[6:0])
         7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: begin
            dec_fmt = FMT_I;
            imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
         end
         7'b0100011: begin
            dec_fmt = FMT_S;
            imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         end
         7'b1100011: begin
            dec_fmt = FMT_B;
            imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                       in_instr[30:25], in_instr[11:8], 1'b0};
         end
         7'b0110111, 7'b0010111: begin
            dec_fmt = FMT_U;
            imm32   = {in_instr[31:12], 12'd0};
         end
         7'b1101111: begin
            dec_fmt = FMT_J;
            imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                       in_instr[20], in_instr[30:21], 1'b0};
         end
         default: dec_illegal = 1'b1;
      endcase
      dec_imm        = {XLEN{imm32[31]}};
      dec_imm[31:0]  = imm32;
   end

   assign in_ready = !skid_valid;
   assign accept   = in_valid && in_ready;
   assign drain    = out_valid && out_ready;

   // The skid register only fills while the output register is stalled, and it empties first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         out_imm      <= '0;
         out_fmt      <= 3'd0;
         out_illegal  <= 1'b0;
         out_tag      <= '0;
         skid_valid   <= 1'b0;
         skid_imm     <= '0;
         skid_fmt     <= 3'd0;
         skid_illegal <= 1'b0;
         skid_tag     <= '0;
      end else if (skid_valid) begin
         if (drain) begin
            out_imm     <= skid_imm;
            out_fmt     <= skid_fmt;
            out_illegal <= skid_illegal;
            out_tag     <= skid_tag;
            skid_valid  <= 1'b0;
         end
      end else if (accept) begin
         if (!out_valid || drain) begin
            out_valid   <= 1'b1;
            out_imm     <= dec_imm;
            out_fmt     <= dec_fmt;
            out_illegal <= dec_illegal;
            out_tag     <= in_tag;
         end else begin
            skid_valid   <= 1'b1;
            skid_imm     <= dec_imm;
            skid_fmt     <= dec_fmt;
            skid_illegal <= dec_illegal;
            skid_tag     <= in_tag;
         end
      end else if (drain) begin
         out_valid <= 1'b0;
      end
   end

   // A clear in the same cycle as an illegal accept still counts that word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegal_cnt <= '0;
      end else if (cnt_clr) begin
         illegal_cnt <= (accept && dec_illegal) ? CNT_W'(1) : '0;
      end else if (accept && dec_illegal && illegal_cnt != CNT_MAX) begin
         illegal_cnt <= illegal_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Scoreboard bench for imm_decode_pipe: the driver queues expected results, the monitor pops and compares on each output handshake.
module tb_imm_decode_pipe;

   typedef struct packed {
      logic [31:0] imm;
      logic [2:0]  fmt;
      logic        ill;
      logic [4:0]  tag;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [4:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_imm;
   logic [2:0]  out_fmt;
   logic        out_illegal;
   logic [4:0]  out_tag;
   logic [1:0]  illegal_cnt;
   logic        cnt_clr;

   logic        in_valid64;
   logic        in_ready64;
   logic [31:0] in_instr64;
   logic [4:0]  in_tag64;
   logic        out_valid64;
   logic        out_ready64;
   logic [63:0] out_imm64;
   logic [2:0]  out_fmt64;
   logic        out_illegal64;
   logic [4:0]  out_tag64;
   logic [7:0]  illegal_cnt64;
   logic        cnt_clr64;

   exp_t        sb[$];
   int          tests_run = 0;
   int          tests_failed = 0;

   logic        prev_armed = 1'b0;
   logic [31:0] prev_imm;
   logic [2:0]  prev_fmt;
   logic        prev_ill;
   logic [4:0]  prev_tag;

   imm_decode_pipe #(.XLEN(32), .TAG_W(5), .CNT_W(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
      .out_illegal(out_illegal), .out_tag(out_tag),
      .illegal_cnt(illegal_cnt), .cnt_clr(cnt_clr)
   );

   imm_decode_pipe #(.XLEN(64), .TAG_W(5), .CNT_W(8)) dut64 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid64), .in_ready(in_ready64), .in_instr(in_instr64), .in_tag(in_tag64),
      .out_valid(out_valid64), .out_ready(out_ready64), .out_imm(out_imm64), .out_fmt(out_fmt64),
      .out_illegal(out_illegal64), .out_tag(out_tag64),
      .illegal_cnt(illegal_cnt64), .cnt_clr(cnt_clr64)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Holds the word on the input until it is accepted, then queues its expected result.
   task automatic apply_stimulus(input logic [31:0] instr, input logic [4:0] tag,
                                 input logic [31:0] imm, input logic [2:0] fmt, input logic ill);
      int   waited = 0;
      logic acc = 1'b0;
      in_valid = 1'b1;
      in_instr = instr;
      in_tag   = tag;
      while (!acc && waited < 50) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         waited++;
      end
      if (acc) begin
         sb.push_back('{imm: imm, fmt: fmt, ill: ill, tag: tag});
      end else begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL accept_timeout: got in_ready 0, expected 1 for tag %0d", tag);
      end
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_empty(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      check_output(name, 64'(sb.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares on every output handshake and checks that stalled outputs hold still.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_armed = 1'b0;
      end else begin
         if (prev_armed) begin
            check_output("stall_imm", 64'(out_imm), 64'(prev_imm));
            check_output("stall_tag", 64'(out_tag), 64'(prev_tag));
            check_output("stall_fmt", 64'(out_fmt), 64'(prev_fmt));
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               tests_run++;
               tests_failed++;
               $display("[TB] FAIL unexpected_output: got tag %0d, expected no output", out_tag);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check_output("imm", 64'(out_imm), 64'(e.imm));
               check_output("fmt", 64'(out_fmt), 64'(e.fmt));
               check_output("illegal", 64'(out_illegal), 64'(e.ill));
               check_output("tag", 64'(out_tag), 64'(e.tag));
            end
         end
         prev_armed = out_valid && !out_ready;
         prev_imm   = out_imm;
         prev_fmt   = out_fmt;
         prev_ill   = out_illegal;
         prev_tag   = out_tag;
      end
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b1; cnt_clr = 1'b0;
      in_valid64 = 1'b0; in_instr64 = '0; in_tag64 = '0; out_ready64 = 1'b1; cnt_clr64 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_output("rst_out_valid", 64'(out_valid), 64'd0);
      check_output("rst_in_ready", 64'(in_ready), 64'd1);
      check_output("rst_out_imm", 64'(out_imm), 64'd0);
      check_output("rst_out_fmt", 64'(out_fmt), 64'd0);
      check_output("rst_illegal_cnt", 64'(illegal_cnt), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed decodes with the consumer always ready.
      apply_stimulus(32'hFFF00093, 5'd7, 32'hFFFFFFFF, 3'd1, 1'b0);
      check_output("addi_latency", 64'(out_valid), 64'd1);
      apply_stimulus(32'hFE112E23, 5'd8, 32'hFFFFFFFC, 3'd2, 1'b0);
      apply_stimulus(32'hFE000EE3, 5'd9, 32'hFFFFFFFC, 3'd3, 1'b0);
      apply_stimulus(32'h008000EF, 5'd10, 32'h00000008, 3'd5, 1'b0);
      apply_stimulus(32'h123452B7, 5'd11, 32'h12345000, 3'd4, 1'b0);
      wait_empty("directed_drain");

      // U-type on the 64-bit instance is sign-extended from bit 31.
      in_valid64 = 1'b1; in_instr64 = 32'h800002B7; in_tag64 = 5'd3;
      @(posedge clk);
      #1 in_valid64 = 1'b0;
      check_output("x64_valid", 64'(out_valid64), 64'd1);
      check_output("x64_imm", out_imm64, 64'hFFFFFFFF80000000);
      check_output("x64_fmt", 64'(out_fmt64), 64'd4);

      // Backpressure: four words back-to-back while the consumer stalls for three cycles.
      out_ready = 1'b0;
      fork
         begin
            apply_stimulus(32'h00500093, 5'd1, 32'h00000005, 3'd1, 1'b0);
            apply_stimulus(32'h80000037, 5'd2, 32'h80000000, 3'd4, 1'b0);
            apply_stimulus(32'h00A12023, 5'd3, 32'h00000000, 3'd2, 1'b0);
            apply_stimulus(32'h0080006F, 5'd4, 32'h00000008, 3'd5, 1'b0);
         end
         begin
            repeat (2) @(posedge clk);
            #1 check_output("bp_in_ready_low", 64'(in_ready), 64'd0);
            check_output("bp_out_valid", 64'(out_valid), 64'd1);
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      wait_empty("bp_drain");

      // Illegal opcodes saturate a 2-bit counter.
      for (int i = 0; i < 5; i++) apply_stimulus(32'h00000000, 5'(20 + i), 32'h0, 3'd0, 1'b1);
      @(posedge clk);
      #1 check_output("cnt_saturated", 64'(illegal_cnt), 64'd3);
      cnt_clr = 1'b1;
      apply_stimulus(32'h00000000, 5'd25, 32'h0, 3'd0, 1'b1);
      cnt_clr = 1'b0;
      check_output("cnt_clr_with_illegal", 64'(illegal_cnt), 64'd1);
      cnt_clr = 1'b1;
      @(posedge clk);
      #1 cnt_clr = 1'b0;
      check_output("cnt_clr_alone", 64'(illegal_cnt), 64'd0);
      wait_empty("illegal_drain");

      // Reset with both output and skid registers full.
      out_ready = 1'b0;
      apply_stimulus(32'h00500093, 5'd14, 32'h00000005, 3'd1, 1'b0);
      apply_stimulus(32'h00500093, 5'd15, 32'h00000005, 3'd1, 1'b0);
      check_output("pre_rst_in_ready", 64'(in_ready), 64'd0);
      #2 rst_n = 1'b0;
      #1;
      check_output("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check_output("mid_rst_in_ready", 64'(in_ready), 64'd1);
      sb.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      apply_stimulus(32'h00100093, 5'd12, 32'h00000001, 3'd1, 1'b0);
      check_output("post_rst_valid", 64'(out_valid), 64'd1);
      wait_empty("post_rst_drain");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/imm_decode_pipe.md
# imm_decode_pipe

Pipelined, parametrised immediate generator for the decode stage. Takes a full 32-bit RV32I instruction word and produces the sign-extended immediate for all five immediate formats (I, S, B, U, J), plus a format code and an illegal-opcode flag. Sits between fetch and the register-read/ALU stage. Uses a valid/ready handshake with a 2-entry skid buffer so backpressure does not create a combinational ready path. Also keeps a saturating count of illegal opcodes for debug.

## Interface

Parameters:
- XLEN, 32, immediate output width; legal values 32 and 64.
- TAG_W, 5, width of the sideband tag passed through unchanged, e.g. rd or ROB index.
- CNT_W, 8, width of the illegal-opcode counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept; equals NOT skid_valid.
- in_instr  in  32  instruction word.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  output holds a decoded result.
- out_ready  in  1  consumer accepts the result.
- out_imm  out  XLEN  sign-extended immediate.
- out_fmt  out  3  0=NONE/illegal, 1=I, 2=S, 3=B, 4=U, 5=J.
- out_illegal  out  1  opcode not recognised.
- out_tag  out  TAG_W  tag of the result.
- illegal_cnt  out  CNT_W  saturating count of accepted illegal words.
- cnt_clr  in  1  synchronous clear of illegal_cnt.

## Operation

Opcode map, using in_instr[6:0]:
- I: 0000011, 0010011, 1100111, 1110011. Immediate is instr[31:20]; shift-immediates get no special handling.
- S: 0100011. Immediate is {instr[31:25], instr[11:7]}.
- B: 1100011. Immediate is {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
- U: 0110111, 0010111. Immediate is {instr[31:12], 12'b0}.
- J: 1101111. Immediate is {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
- Any other opcode: out_fmt=0, out_imm=0, out_illegal=1.

Extension and datapath:
- Every immediate is sign-extended from instr[31] to XLEN bits. This includes U-type when XLEN=64.
- Decode is combinational on the input side. Results are registered into the output register or the skid register; the tag travels with its word.

Storage and ordering:
- Storage is an output register (out_valid) plus one skid register (skid_valid).
- Strict FIFO order; no word is dropped or duplicated.

Illegal-opcode counter:
- Increments by 1 on each input handshake whose word is illegal.
- Saturates at 2^CNT_W-1.
- If cnt_clr is asserted alone, the next value is 0.
- If cnt_clr and an illegal accept occur in the same cycle, the next value is 1.

## Timing

Reset (rst_n low, asynchronous):
- out_valid=0, skid_valid=0, in_ready=1.
- out_imm, out_fmt, out_tag and illegal_cnt are 0; out_illegal=0.
- in_valid is ignored while rst_n is low.
- Reset mid-stream discards every held word.

Handshake rules:
- Input handshake occurs when in_valid && in_ready. Output handshake occurs when out_valid && out_ready.
- Latency is 1 cycle: a word accepted at edge N appears on the outputs after edge N, provided the output register is free or draining.
- Throughput is one word per cycle while out_ready stays high.

Per-edge update rules:
- Output register empty, or draining this cycle, and skid empty: an accepted word loads the output register.
- Output register full and not draining: an accepted word loads the skid register, and in_ready drops next cycle.
- Output drains while the skid is full: the skid word moves to the output register and skid_valid clears. in_ready is low that cycle, so no input is accepted.
- Output drains with no new input and the skid empty: out_valid clears.

Output stability:
- out_* stay stable while out_valid && !out_ready.
- in_ready has no combinational path from out_ready.

## Test plan

- I-type and S-type, XLEN=32:
  - 0xFFF00093 (addi x1,x0,-1) -> out_imm 0xFFFFFFFF, fmt 1, out_valid one cycle after accept.
  - 0xFE112E23 (sw x1,-4(x2)) -> out_imm 0xFFFFFFFC, fmt 2.
- B-type and J-type:
  - 0xFE000EE3 (beq -4) -> out_imm 0xFFFFFFFC, fmt 3.
  - 0x008000EF (jal x1,8) -> out_imm 0x00000008, fmt 5.
- U-type:
  - 0x123452B7, XLEN=32 -> out_imm 0x12345000, fmt 4.
  - 0x800002B7, XLEN=64 -> out_imm 0xFFFFFFFF80000000.
- Backpressure: stream 4 words back-to-back with tags 1-4 and hold out_ready=0 for 3 cycles.
  - in_ready drops after 2 accepts.
  - Tags emerge in order 1,2,3,4 with no loss or duplication.
  - Stalled outputs stay stable.
- Illegal opcodes, CNT_W=2: send 0x00000000 five times.
  - Each result gives fmt 0, imm 0, illegal 1.
  - illegal_cnt reads 3 (saturated).
  - cnt_clr together with a further illegal word -> illegal_cnt 1.
- Reset mid-stream: assert rst_n low while both output and skid registers are full.
  - out_valid=0 and in_ready=1 immediately.
  - The first word after reset is decoded normally.
